// File: rtl/vram_port_arbiter.sv
// Arbitrates a single-port synchronous VRAM between a capture writer and a
// scan-out reader: reads win, a starvation counter bounds write wait time.
module vram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_grant_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_grant_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  localparam int         STAGES = 3;
  localparam logic [7:0] MAX_W  = 8'(MAX_WAIT);

  logic [7:0]      wait_cnt;
  logic            starve;
  logic [STAGES:0] vld_pipe;

  always_comb begin
    starve     = wr_req_i && (wait_cnt == MAX_W);
    wr_grant_o = !reset_i && wr_req_i && (!rd_req_i || starve);
    rd_grant_o = !reset_i && rd_req_i && !wr_grant_o;
  end

  // Consecutive reads a pending write has lost to; saturates at MAX_WAIT.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      wait_cnt <= '0;
    else if (!wr_req_i || wr_grant_o)
      wait_cnt <= '0;
    else if (rd_grant_o && wait_cnt < MAX_W)
      wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else if (wr_grant_o) begin
      ram_en_o   <= 1'b1;
      ram_we_o   <= 1'b1;
      ram_addr_o <= wr_addr_i;
      ram_data_o <= wr_data_i;
    end else if (rd_grant_o) begin
      ram_en_o   <= 1'b1;
      ram_we_o   <= 1'b0;
      ram_addr_o <= rd_addr_i;
    end else begin
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
    end
  end

  // Stage 1: command on the RAM pins; stage 2: ram_data_i valid; stage 3: rd_valid_o.
  assign vld_pipe[0] = rd_grant_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) vld_pipe[STAGES:1] <= '0;
    else         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)              rd_data_o <= '0;
    else if (vld_pipe[STAGES-1]) rd_data_o <= ram_data_i;
  end

  assign rd_valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised scoreboard bench for vram_port_arbiter with a behavioural VRAM
// and a reference model of the arbitration rules.
module tb_vram_port_arbiter;
  localparam int MW = 4;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] due;
  } rd_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       wr_req_i = 1'b0, rd_req_i = 1'b0;
  logic [7:0] wr_addr_i = '0, wr_data_i = '0, rd_addr_i = '0;
  logic       wr_grant_o, rd_grant_o, rd_valid_o;
  logic [7:0] rd_data_o;
  logic       ram_en_o, ram_we_o;
  logic [7:0] ram_addr_o, ram_data_o;
  logic [7:0] ram_data_i = '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  cmd_t       cmd_q[$];
  rd_t        rd_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] mem [256];
  bit         mem_clr = 1'b1;
  int         losses = 0;
  logic [7:0] last_addr = '0, last_data = '0, exp_rd_data = '0;
  bit         in_reset = 1'b1;

  vram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WAIT(MW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_grant_o(wr_grant_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_grant_o(rd_grant_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
      else          ram_data_i <= mem[ram_addr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares RAM commands and read returns against the scoreboard.
  always @(posedge clk) begin
    #2;
    if (!in_reset) begin
      if (cmd_q.size() > 0) begin
        cmd_t c;
        c = cmd_q.pop_front();
        check("ram_en", ram_en_o, c.en);
        check("ram_we", ram_we_o, c.we);
        check("ram_addr", ram_addr_o, c.addr);
        check("ram_data", ram_data_o, c.data);
      end
      if (rd_valid_o) begin
        if (rd_q.size() == 0) begin
          check("unexpected rd_valid", 1, 0);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check("rd_data", rd_data_o, r.data);
          check("rd_latency", cyc, r.due);
          exp_rd_data = r.data;
        end
      end else begin
        check("rd_data hold", rd_data_o, exp_rd_data);
        if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
          check("missing rd_valid", 0, 1);
          void'(rd_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; the reference model predicts grants and effects.
  task automatic step(input bit wr, input logic [7:0] wa, input logic [7:0] wd,
                      input bit rd, input logic [7:0] ra,
                      output bit awg, output bit arg);
    bit ewg, erg;
    cmd_t c;
    rd_t r;
    @(posedge clk); #1;
    wr_req_i = wr; wr_addr_i = wa; wr_data_i = wd;
    rd_req_i = rd; rd_addr_i = ra;
    @(negedge clk);
    ewg = wr && (!rd || losses == MW);
    erg = rd && !ewg;
    awg = wr_grant_o;
    arg = rd_grant_o;
    check("wr_grant", wr_grant_o, ewg);
    check("rd_grant", rd_grant_o, erg);
    check("grant exclusive", wr_grant_o & rd_grant_o, 0);
    if (ewg) begin
      ref_mem[wa] = wd;
      last_addr = wa; last_data = wd;
      c = '{en: 1'b1, we: 1'b1, addr: wa, data: wd};
    end else if (erg) begin
      last_addr = ra;
      c = '{en: 1'b1, we: 1'b0, addr: ra, data: last_data};
      r = '{data: ref_mem[ra], due: 32'(cyc + 3)};
      rd_q.push_back(r);
    end else begin
      c = '{en: 1'b0, we: 1'b0, addr: last_addr, data: last_data};
    end
    cmd_q.push_back(c);
    if (!wr || ewg) losses = 0;
    else if (erg && losses < MW) losses++;
  endtask

  task automatic idle();
    bit g1, g2;
    step(0, 0, 0, 0, 0, g1, g2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ram_en"}, ram_en_o, 0);
    check({tag, " ram_we"}, ram_we_o, 0);
    check({tag, " ram_addr"}, ram_addr_o, 0);
    check({tag, " ram_data"}, ram_data_o, 0);
    check({tag, " rd_valid"}, rd_valid_o, 0);
    check({tag, " rd_data"}, rd_data_o, 0);
    check({tag, " wr_grant"}, wr_grant_o, 0);
    check({tag, " rd_grant"}, rd_grant_o, 0);
  endtask

  initial begin
    bit wg, rg;
    bit wp, rp;
    logic [7:0] wa, wd, ra;
    string pat;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    wr_req_i = 1'b1; rd_req_i = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("init reset");
    mem_clr = 1'b0;
    @(posedge clk); #1;
    wr_req_i = 1'b0; rd_req_i = 1'b0;
    reset_i = 1'b0;
    in_reset = 1'b0;

    // Write-only burst.
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 8'hA0 + 8'(i), 0, 0, wg, rg);
    // Read-only burst of the same addresses.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h10 + 8'(i), wg, rg);
    repeat (4) idle();

    // Contention: both held, expect R x MW then W.
    pat = "";
    for (int i = 0; i < 15; i++) begin
      step(1, 8'h40 + 8'(i), 8'(i), 1, 8'h10 + 8'(i % 4), wg, rg);
      pat = {pat, wg ? "W" : (rg ? "R" : "-")};
    end
    tests++;
    if (pat != "RRRRWRRRRWRRRRW") begin
      fails++;
      $display("FAIL contention pattern: got %s, expected RRRRWRRRRWRRRRW", pat);
    end
    idle();

    // Read-after-write to the same address.
    step(1, 8'h20, 8'h5C, 0, 0, wg, rg);
    step(0, 0, 0, 1, 8'h20, wg, rg);
    repeat (4) idle();

    // Write withdrawn before grant clears the wait count.
    step(1, 8'h30, 8'h11, 1, 8'h01, wg, rg);
    step(1, 8'h30, 8'h11, 1, 8'h02, wg, rg);
    step(0, 0, 0, 1, 8'h03, wg, rg);
    for (int i = 0; i < 6; i++) step(1, 8'h31, 8'h22, 1, 8'h04, wg, rg);
    repeat (4) idle();

    // Reset with reads in flight.
    step(0, 0, 0, 1, 8'h10, wg, rg);
    step(0, 0, 0, 1, 8'h11, wg, rg);
    @(posedge clk); #1;
    wr_req_i = 1'b1; rd_req_i = 1'b1;
    #3;
    reset_i = 1'b1;
    in_reset = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    cmd_q.delete(); rd_q.delete();
    losses = 0; last_addr = '0; last_data = '0; exp_rd_data = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset wr_grant", wr_grant_o, 0);
      check("reset rd_grant", rd_grant_o, 0);
    end
    @(posedge clk); #1;
    wr_req_i = 1'b0; rd_req_i = 1'b0;
    reset_i = 1'b0;
    in_reset = 1'b0;
    repeat (5) idle();

    // Random traffic with a held-until-granted handshake.
    wp = 0; rp = 0; wa = 0; wd = 0; ra = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!wp && ($urandom % 3 != 0)) begin
        wp = 1; wa = 8'($urandom % 16); wd = 8'($urandom);
      end
      if (!rp && ($urandom % 2 == 0)) begin
        rp = 1; ra = 8'($urandom % 16);
      end
      step(wp, wa, wd, rp, ra, wg, rg);
      if (wg) wp = 0;
      if (rg) rp = 0;
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && (rd_q.size() > 0 || cmd_q.size() > 0); i++) idle();
    @(posedge clk); #3;
    check("read queue drained", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
